// File: rtl/merge_run_scheduler_if.sv
// Control bundle between the merge run scheduler and its input/output FIFO environment.
// The slave modport is the scheduler side; the master modport is the FIFO/credit side.
interface merge_run_scheduler_if #(
    parameter int unsigned OUT_FIFO_DEPTH = 32,
    parameter int unsigned CNT_WIDTH      = 32
);
    localparam int unsigned CRED_W = $clog2(OUT_FIFO_DEPTH) + 1;

    logic                 i_a_empty;
    logic                 i_b_empty;
    logic                 i_a_min_zero;
    logic                 i_b_min_zero;
    logic                 i_a_lte_b;
    logic                 i_out_deq;
    logic                 o_select_a;
    logic                 o_stall;
    logic                 o_last;
    logic                 o_drop_b;
    logic                 o_run_done;
    logic [CNT_WIDTH-1:0] o_run_len;
    logic [CRED_W-1:0]    o_credits;
    logic [2:0]           o_state;

    modport slave (
        input  i_a_empty, i_b_empty, i_a_min_zero, i_b_min_zero, i_a_lte_b, i_out_deq,
        output o_select_a, o_stall, o_last, o_drop_b, o_run_done, o_run_len, o_credits, o_state
    );

    modport master (
        output i_a_empty, i_b_empty, i_a_min_zero, i_b_min_zero, i_a_lte_b, i_out_deq,
        input  o_select_a, o_stall, o_last, o_drop_b, o_run_done, o_run_len, o_credits, o_state
    );
endinterface

// File: rtl/merge_run_scheduler.sv
// Two-way merge scheduler for sentinel-terminated sorted runs, gated by output-FIFO credits.
// Issues the smaller head, drains the survivor, emits A's sentinel as the run terminator and drops B's.
module merge_run_scheduler #(
    parameter int unsigned OUT_FIFO_DEPTH = 32,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    merge_run_scheduler_if.slave   bus
);
    localparam int unsigned          CRED_W   = $clog2(OUT_FIFO_DEPTH) + 1;
    localparam logic [CRED_W-1:0]    CRED_MAX = CRED_W'(OUT_FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MERGE   = 3'd1,
        S_DRAIN_A = 3'd2,
        S_DRAIN_B = 3'd3,
        S_FLUSH_A = 3'd4,
        S_FLUSH_B = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CRED_W-1:0]    r_credits;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_run_len;
    logic                 r_run_done;
    logic                 w_select_a;
    logic                 w_stall;
    logic                 w_last;
    logic                 w_drop_b;
    logic                 w_has_credit;
    logic                 w_issue;

    assign w_has_credit = (r_credits != '0);
    assign w_issue      = ~w_stall;

    // Next-state and issue decode; sentinel transitions never dequeue.
    always_comb begin
        w_next     = r_state;
        w_select_a = 1'b0;
        w_stall    = 1'b1;
        w_last     = 1'b0;
        w_drop_b   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.i_a_empty && !bus.i_b_empty) w_next = S_MERGE;
            end
            S_MERGE: begin
                if (!bus.i_a_empty && !bus.i_b_empty) begin
                    if (bus.i_a_min_zero && bus.i_b_min_zero) w_next = S_FLUSH_A;
                    else if (bus.i_a_min_zero)                w_next = S_DRAIN_B;
                    else if (bus.i_b_min_zero)                w_next = S_DRAIN_A;
                    else begin
                        w_select_a = bus.i_a_lte_b;
                        w_stall    = ~w_has_credit;
                    end
                end
            end
            S_DRAIN_A: begin
                w_select_a = 1'b1;
                if (!bus.i_a_empty) begin
                    if (bus.i_a_min_zero) w_next  = S_FLUSH_A;
                    else                  w_stall = ~w_has_credit;
                end
            end
            S_DRAIN_B: begin
                if (!bus.i_b_empty) begin
                    if (bus.i_b_min_zero) w_next  = S_FLUSH_A;
                    else                  w_stall = ~w_has_credit;
                end
            end
            S_FLUSH_A: begin
                w_select_a = 1'b1;
                w_last     = 1'b1;
                if (!bus.i_a_empty && w_has_credit) begin
                    w_stall = 1'b0;
                    w_next  = S_FLUSH_B;
                end
            end
            S_FLUSH_B: begin
                if (!bus.i_b_empty) begin
                    w_drop_b = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Quiet the FIFO side while reset is held, whatever the state register says.
        if (!i_rst_n) begin
            w_stall  = 1'b1;
            w_last   = 1'b0;
            w_drop_b = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Credits track free output-FIFO slots; a return at full credit is ignored.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_credits <= CRED_MAX;
        end else if (w_issue && !bus.i_out_deq) begin
            r_credits <= r_credits - CRED_W'(1);
        end else if (!w_issue && bus.i_out_deq && (r_credits != CRED_MAX)) begin
            r_credits <= r_credits + CRED_W'(1);
        end
    end

    // Run-length accounting; the drop of B's sentinel closes the run.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count    <= '0;
            r_run_len  <= '0;
            r_run_done <= 1'b0;
        end else begin
            r_run_done <= w_drop_b;
            if (w_drop_b) begin
                r_run_len <= r_count;
                r_count   <= '0;
            end else if (w_issue && !w_last && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.o_select_a = w_select_a;
    assign bus.o_stall    = w_stall;
    assign bus.o_last     = w_last;
    assign bus.o_drop_b   = w_drop_b;
    assign bus.o_run_done = r_run_done;
    assign bus.o_run_len  = r_run_len;
    assign bus.o_credits  = r_credits;
    assign bus.o_state    = 3'(r_state);
endmodule

// File: tb/tb_merge_run_scheduler.sv
// Scoreboard bench for merge_run_scheduler: modelled input FIFOs, a merge reference model
// feeding an expected-issue queue, and a monitor comparing every issue, run length and credit.
module tb_merge_run_scheduler;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    merge_run_scheduler_if #(.OUT_FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

    merge_run_scheduler #(.OUT_FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int val;
        bit from_a;
        bit last;
    } exp_t;

    int   qa[$];
    int   qb[$];
    int   la[$];
    int   lb[$];
    exp_t exp_q[$];
    int   len_q[$];
    int   st_trace[$];

    int n_vec = 0;
    int n_err = 0;
    int total_issues = 0;
    int deq_mode = 0;
    bit b_starve = 1'b0;
    bit trace_en = 1'b0;
    int model_cred = DEPTH;
    bit prev_rst = 1'b0;

    bit obs_issue = 1'b0;
    bit obs_from_a = 1'b0;
    bit obs_last = 1'b0;
    bit obs_drop = 1'b0;
    bit obs_deq = 1'b0;
    bit obs_valid = 1'b0;
    int obs_val = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: plain sorted merge, ties to A, then A's sentinel as the terminator.
    task automatic load_run();
        int   i = 0;
        int   j = 0;
        exp_t e;
        while (i < la.size() && j < lb.size()) begin
            if (la[i] <= lb[j]) begin e = '{la[i], 1'b1, 1'b0}; i++; end
            else                begin e = '{lb[j], 1'b0, 1'b0}; j++; end
            exp_q.push_back(e);
        end
        while (i < la.size()) begin e = '{la[i], 1'b1, 1'b0}; exp_q.push_back(e); i++; end
        while (j < lb.size()) begin e = '{lb[j], 1'b0, 1'b0}; exp_q.push_back(e); j++; end
        e = '{0, 1'b1, 1'b1};
        exp_q.push_back(e);
        len_q.push_back(la.size() + lb.size());
        foreach (la[k]) qa.push_back(la[k]);
        qa.push_back(0);
        foreach (lb[k]) qb.push_back(lb[k]);
        qb.push_back(0);
    endtask

    task automatic gen_lists(input int na, input int nb);
        int v;
        la.delete();
        lb.delete();
        v = 0;
        repeat (na) begin v += int'($urandom_range(1, 20)); la.push_back(v); end
        v = 0;
        repeat (nb) begin v += int'($urandom_range(1, 20)); lb.push_back(v); end
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0 || len_q.size() != 0) fail({name, "_timeout"});
        repeat (3) @(posedge clk);
    endtask

    // FIFO environment: apply last cycle's dequeues, present heads, sample the decision.
    initial begin
        forever begin
            @(negedge clk);
            if (obs_issue) begin
                if (obs_from_a) begin
                    if (qa.size() > 0) qa.delete(0);
                end else if (qb.size() > 0) begin
                    qb.delete(0);
                end
            end
            if (obs_drop && qb.size() > 0) qb.delete(0);
            bus.i_a_empty    = (qa.size() == 0);
            bus.i_b_empty    = b_starve || (qb.size() == 0);
            bus.i_a_min_zero = (qa.size() > 0) && (qa[0] == 0);
            bus.i_b_min_zero = !b_starve && (qb.size() > 0) && (qb[0] == 0);
            bus.i_a_lte_b    = (qa.size() > 0) && (qb.size() > 0) && (qa[0] <= qb[0]);
            bus.i_out_deq    = (deq_mode == 1) ? 1'b1 :
                               (deq_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #2;
            obs_issue  = !bus.o_stall;
            obs_from_a = bus.o_select_a;
            obs_last   = bus.o_last;
            obs_drop   = bus.o_drop_b;
            obs_deq    = bus.i_out_deq;
            obs_valid  = 1'b1;
            obs_val    = 0;
            if (obs_issue) begin
                if (obs_from_a) begin
                    if (qa.size() > 0) obs_val = qa[0]; else obs_valid = 1'b0;
                end else begin
                    if (qb.size() > 0 && !b_starve) obs_val = qb[0]; else obs_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every issue and run_done, tracks credits arithmetically.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                chk("rst_stall", bus.o_stall, 1);
                chk("rst_last", bus.o_last, 0);
                chk("rst_drop_b", bus.o_drop_b, 0);
                model_cred = DEPTH;
                prev_rst   = 1'b1;
            end else begin
                if (prev_rst) begin
                    chk("post_rst_state", bus.o_state, 0);
                    chk("post_rst_credits", bus.o_credits, DEPTH);
                    chk("post_rst_run_done", bus.o_run_done, 0);
                    prev_rst = 1'b0;
                end
                chk("credits", bus.o_credits, model_cred);
                if (trace_en) st_trace.push_back(int'(bus.o_state));
                if (bus.o_run_done) begin
                    if (len_q.size() == 0) fail("run_done_unexpected");
                    else chk("run_len", bus.o_run_len, len_q.pop_front());
                end
                if (bus.o_state == 3'd1 && (bus.i_a_empty || bus.i_b_empty))
                    chk("merge_empty_stall", bus.o_stall, 1);
                if (obs_issue) begin
                    total_issues++;
                    chk("issue_has_credit", (model_cred > 0) ? 1 : 0, 1);
                    if (!obs_valid) fail("issue_from_empty_fifo");
                    else if (exp_q.size() == 0) fail("issue_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("issue_value", obs_val, e.val);
                        chk("issue_select_a", obs_from_a, e.from_a);
                        chk("issue_last", obs_last, e.last);
                    end
                end
                if (obs_issue && !obs_deq) model_cred--;
                else if (!obs_issue && obs_deq && model_cred < DEPTH) model_cred++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int dd[$];
        int exp_tr[5];

        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed merge A={1,4,9}, B={2,3}.
        deq_mode = 1;
        la = '{1, 4, 9};
        lb = '{2, 3};
        load_run();
        wait_drain(200, "directed_merge");

        // Both heads sentinel: IDLE, MERGE, FLUSH_A, FLUSH_B, IDLE with zero length.
        st_trace.delete();
        trace_en = 1'b1;
        la.delete();
        lb.delete();
        load_run();
        wait_drain(200, "empty_run");
        trace_en = 1'b0;
        foreach (st_trace[k]) if (dd.size() == 0 || dd[dd.size()-1] != st_trace[k]) dd.push_back(st_trace[k]);
        exp_tr = '{0, 1, 4, 5, 0};
        chk("empty_run_trace_len", dd.size(), 5);
        for (int k = 0; k < 5; k++) chk("empty_run_trace_state", (k < dd.size()) ? dd[k] : -1, exp_tr[k]);

        // Credit limit: no returns, only DEPTH issues, then a single return buys one more.
        deq_mode = 0;
        gen_lists(10, 10);
        load_run();
        base = total_issues;
        repeat (15) @(posedge clk);
        #3;
        chk("credit_limit_issues", total_issues - base, DEPTH);
        chk("credit_limit_stall", bus.o_stall, 1);
        chk("credit_limit_credits", bus.o_credits, 0);
        @(posedge clk);
        deq_mode = 1;
        @(posedge clk);
        deq_mode = 0;
        repeat (10) @(posedge clk);
        chk("credit_pulse_issues", total_issues - base, DEPTH + 1);
        deq_mode = 1;
        wait_drain(400, "credit_limit");

        // Simultaneous issue and return hold credits steady.
        gen_lists(20, 20);
        load_run();
        repeat (3) @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #3;
            chk("credits_constant", bus.o_credits, DEPTH);
        end
        wait_drain(400, "credit_steady");

        // Starve B mid-merge, then let it refill.
        la.delete();
        lb.delete();
        for (int k = 1; k <= 10; k++) begin la.push_back(2 * k); lb.push_back(2 * k - 1); end
        load_run();
        base = total_issues;
        n = 0;
        while (total_issues - base < 2 && n < 100) begin @(posedge clk); n++; end
        if (total_issues - base < 2) fail("starve_setup_timeout");
        b_starve = 1'b1;
        base = total_issues;
        repeat (5) @(posedge clk);
        chk("starve_no_issue", total_issues - base, 0);
        b_starve = 1'b0;
        wait_drain(400, "starve");

        // Reset right after the third issue of a run: run abandoned, no run_done.
        gen_lists(6, 6);
        load_run();
        base = total_issues;
        n = 0;
        while (total_issues - base < 3 && n < 100) begin @(posedge clk); n++; end
        if (total_issues - base < 3) fail("reset_setup_timeout");
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        exp_q.delete();
        len_q.delete();
        @(posedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);

        // Randomized back-to-back runs with random credit returns.
        deq_mode = 2;
        for (int r = 0; r < 12; r++) begin
            gen_lists(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
            load_run();
        end
        wait_drain(4000, "random_runs");
        deq_mode = 1;
        repeat (10) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
